cache_mem_arbiter: RTL and testbench
====================================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, main-memory byte address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache line width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles to wait for m_resp; legal range 1..1023.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 i_read, i_write  in  1 each  I-cache line fill / writeback request; held until i_resp.
REQ-007 i_addr  in  ADDR_W  I-cache line address; i_wdata  in  LINE_W  I-cache writeback data.
REQ-008 i_rdata  out  LINE_W  fill data to I-cache; i_resp  out  1  one-cycle completion pulse.
REQ-009 d_read, d_write, d_addr, d_wdata, d_rdata, d_resp: same directions, widths and meaning as the i_* ports, for the D-cache.
REQ-010 m_read, m_write  out  1 each  main-memory request, held until m_resp or timeout.
REQ-011 m_addr  out  ADDR_W; m_wdata  out  LINE_W; m_rdata  in  LINE_W; m_resp  in  1  one-cycle completion pulse.
REQ-012 grant  out  2  current owner: 2'b01 I, 2'b10 D, 2'b00 none.
REQ-013 err  out  1  sticky timeout flag.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT_I, GRANT_D, RELEASE, TIMEOUT_ERR.
REQ-015 IDLE: request from I only (i_read|i_write) -> GRANT_I; D only -> GRANT_D; neither -> IDLE.
REQ-016 IDLE, both requesting: grant the requester not in register last_grant (round robin); last_grant updates on each grant.
REQ-017 On IDLE->GRANT_x, SHALL register x_addr, x_wdata and op (write if x_write=1, else read); x_read and x_write both high is treated as write.
REQ-018 In GRANT_x: m_read/m_write = registered op, m_addr/m_wdata = registered values; grant = owner; all driven from registers/state only.
REQ-019 First m_read/m_write assertion SHALL occur the cycle after the request is first seen in IDLE (1-cycle arbitration latency).
REQ-020 In GRANT_x with m_resp=1: x_resp=1 same cycle, x_rdata=m_rdata same cycle (combinational), next state RELEASE.
REQ-021 x_rdata SHALL equal m_rdata whenever grant selects x, else all zeros; non-owner resp SHALL be 0 always.
REQ-022 m_resp received in IDLE or RELEASE SHALL be ignored (no resp to any requester).
REQ-023 RELEASE: one dead cycle, m_* and grant deasserted, then IDLE; guarantees requester has dropped its request before re-arbitration.
REQ-024 Wait counter (10 bits) SHALL clear on entry to GRANT_x and increment each GRANT_x cycle without m_resp.
REQ-025 Counter reaching TIMEOUT without m_resp -> TIMEOUT_ERR: m_* low, x_resp=1 for one cycle, x_rdata=0, err set, next RELEASE.
REQ-026 err SHALL stay 1 until rst; arbitration continues normally after a timeout.
REQ-027 m_resp in same cycle counter hits TIMEOUT: completion wins, no error.
REQ-028 A requester dropping its request mid-grant SHALL NOT abort the memory transaction; completion proceeds, resp still pulsed.

Reset
REQ-029 rst SHALL force state IDLE, last_grant=I (so D wins the first conflict), counter=0, err=0.
REQ-030 During and on the cycle after rst: m_read=m_write=0, i_resp=d_resp=0, grant=00, rdata outputs 0.
REQ-031 rst mid-transaction SHALL abandon it with no resp pulse; a later m_resp for it is ignored per REQ-022.

Verification
REQ-032 Single D read addr 0x100, m_resp 5 cycles after m_read with m_rdata=0xA5..A5 -> m_addr=0x100, d_resp pulse with data 0xA5..A5, grant=10 throughout, then RELEASE, IDLE.
REQ-033 I and D request same cycle after reset -> D granted first, I granted after D completes + RELEASE; repeat conflict -> I first.
REQ-034 D writeback (d_write, d_wdata=0x1234..) then d_read back-to-back -> m_write with data, d_resp, RELEASE, then m_read; no overlap of m_read/m_write.
REQ-035 TIMEOUT=8, memory never responds -> m_read high 8 cycles, then d_resp pulse with d_rdata=0, err=1 sticky, next request served normally.
REQ-036 rst asserted in GRANT_I mid-wait, stray m_resp afterward -> all outputs at reset values, no i_resp pulse, err=0.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the I-cache, D-cache, main memory and the arbiter.
// slave is the arbiter's view; master is the surrounding caches/memory view.
interface cache_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 128
);
    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_wdata;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    logic              m_resp;

    logic [1:0]        grant;
    logic              err;

    modport slave (
        input  i_read, i_write, i_addr, i_wdata,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_resp,
        output m_read, m_write, m_addr, m_wdata,
        input  m_rdata, m_resp,
        output grant, err
    );

    modport master (
        output i_read, i_write, i_addr, i_wdata,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  m_read, m_write, m_addr, m_wdata,
        output m_rdata, m_resp,
        input  grant, err
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and D-cache,
// with a per-transaction response timeout and a sticky error flag.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    cache_mem_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W    = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        RELEASE,
        TIMEOUT_ERR
    } state_t;

    state_t            state;
    logic              owner_d;
    logic              last_d;
    logic              m_read_q;
    logic              m_write_q;
    logic [1:0]        grant_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic              i_req;
    logic              d_req;
    logic              pick_d;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_wdata;
    logic [1:0]        grant_o;

    // Arbitration choice: D wins when alone, or in a conflict when I owned the port last.
    always_comb begin
        i_req     = bus.i_read | bus.i_write;
        d_req     = bus.d_read | bus.d_write;
        pick_d    = d_req & (~i_req | ~last_d);
        sel_write = pick_d ? bus.d_write : bus.i_write;
        sel_addr  = pick_d ? bus.d_addr  : bus.i_addr;
        sel_wdata = pick_d ? bus.d_wdata : bus.i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            last_d    <= 1'b0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            grant_q   <= 2'b00;
            err_q     <= 1'b0;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        state     <= pick_d ? GRANT_D : GRANT_I;
                        owner_d   <= pick_d;
                        last_d    <= pick_d;
                        m_write_q <= sel_write;
                        m_read_q  <= ~sel_write;
                        addr_q    <= sel_addr;
                        wdata_q   <= sel_wdata;
                        grant_q   <= pick_d ? 2'b10 : 2'b01;
                        cnt       <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    // A response on the final allowed cycle still completes normally.
                    if (bus.m_resp) begin
                        state     <= RELEASE;
                        m_read_q  <= 1'b0;
                        m_write_q <= 1'b0;
                        grant_q   <= 2'b00;
                    end else if (cnt == CNT_LAST) begin
                        state     <= TIMEOUT_ERR;
                        m_read_q  <= 1'b0;
                        m_write_q <= 1'b0;
                        grant_q   <= 2'b00;
                        err_q     <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TIMEOUT_ERR: state <= RELEASE;
                RELEASE:     state <= IDLE;
                default:     state <= IDLE;
            endcase
        end
    end

    // Outputs are held quiet while rst is high, even before the reset edge lands.
    assign grant_o     = rst ? 2'b00 : grant_q;
    assign bus.grant   = grant_o;
    assign bus.err     = err_q;
    assign bus.m_read  = m_read_q & ~rst;
    assign bus.m_write = m_write_q & ~rst;
    assign bus.m_addr  = (grant_o != 2'b00) ? addr_q  : '0;
    assign bus.m_wdata = (grant_o != 2'b00) ? wdata_q : '0;

    assign bus.i_resp  = ~rst & (((state == GRANT_I) & bus.m_resp) |
                                 ((state == TIMEOUT_ERR) & ~owner_d));
    assign bus.d_resp  = ~rst & (((state == GRANT_D) & bus.m_resp) |
                                 ((state == TIMEOUT_ERR) & owner_d));
    assign bus.i_rdata = (grant_o == 2'b01) ? bus.m_rdata : '0;
    assign bus.d_rdata = (grant_o == 2'b10) ? bus.m_rdata : '0;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed vector bench for cache_mem_arbiter (TIMEOUT=8).
module tb_cache_mem_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 128;
    localparam logic [LINE_W-1:0] RDATA   = {16{8'hA5}};
    localparam logic [LINE_W-1:0] I_WDATA = {8{16'hBEEF}};
    localparam logic [LINE_W-1:0] D_WDATA = {8{16'h1234}};
    localparam logic [ADDR_W-1:0] I_ADDR  = 32'h0000_0200;
    localparam logic [ADDR_W-1:0] D_ADDR  = 32'h0000_0100;

    typedef struct {
        logic [4:0]  in;     // {i_read, i_write, d_read, d_write, m_resp}
        logic [1:0]  mrw;    // expected {m_read, m_write}
        logic [1:0]  grant;
        logic [1:0]  resp;   // expected {i_resp, d_resp}
        logic [31:0] addr;   // expected m_addr
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    vec_t vecs[$];
    vec_t v;
    logic [LINE_W-1:0] exp_ird;
    logic [LINE_W-1:0] exp_drd;
    logic [LINE_W-1:0] exp_wd;

    cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic chk_out(input string tag, input logic mr, input logic [1:0] gr,
                           input logic ir, input logic dr, input logic e);
        chk({tag, " m_read"}, 128'(bus.m_read), 128'(mr));
        chk({tag, " m_write"}, 128'(bus.m_write), 128'(1'b0));
        chk({tag, " grant"}, 128'(bus.grant), 128'(gr));
        chk({tag, " i_resp"}, 128'(bus.i_resp), 128'(ir));
        chk({tag, " d_resp"}, 128'(bus.d_resp), 128'(dr));
        chk({tag, " err"}, 128'(bus.err), 128'(e));
    endtask

    function automatic vec_t mk(input logic [4:0] in, input logic [1:0] mrw,
                                input logic [1:0] gr, input logic [1:0] resp,
                                input logic [31:0] addr);
        vec_t r;
        r.in = in; r.mrw = mrw; r.grant = gr; r.resp = resp; r.addr = addr;
        return r;
    endfunction

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b1;
        bus.i_read = 1'b0; bus.i_write = 1'b0; bus.i_addr = I_ADDR; bus.i_wdata = I_WDATA;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = D_ADDR; bus.d_wdata = D_WDATA;
        bus.m_rdata = RDATA; bus.m_resp = 1'b0;

        // Conflict after reset: D first, then I on the repeat conflict, then D again.
        vecs.push_back(mk(5'b10100, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b10101, 2'b10, 2'b10, 2'b01, 32'h100));
        vecs.push_back(mk(5'b10100, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b10100, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b10101, 2'b10, 2'b01, 2'b10, 32'h200));
        vecs.push_back(mk(5'b00100, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b00100, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b00101, 2'b10, 2'b10, 2'b01, 32'h100));
        vecs.push_back(mk(5'b00000, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b00000, 2'b00, 2'b00, 2'b00, 32'h0));
        // Single D read, memory answers 5 cycles after m_read rises.
        vecs.push_back(mk(5'b00100, 2'b00, 2'b00, 2'b00, 32'h0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(5'b00100, 2'b10, 2'b10, 2'b00, 32'h100));
        vecs.push_back(mk(5'b00101, 2'b10, 2'b10, 2'b01, 32'h100));
        vecs.push_back(mk(5'b00000, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b00000, 2'b00, 2'b00, 2'b00, 32'h0));
        // D writeback then read back-to-back.
        vecs.push_back(mk(5'b00010, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b00010, 2'b01, 2'b10, 2'b00, 32'h100));
        vecs.push_back(mk(5'b00011, 2'b01, 2'b10, 2'b01, 32'h100));
        vecs.push_back(mk(5'b00100, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b00100, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b00101, 2'b10, 2'b10, 2'b01, 32'h100));
        vecs.push_back(mk(5'b00000, 2'b00, 2'b00, 2'b00, 32'h0));
        // I with read and write both high is a write.
        vecs.push_back(mk(5'b11000, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b11001, 2'b01, 2'b01, 2'b10, 32'h200));
        vecs.push_back(mk(5'b00000, 2'b00, 2'b00, 2'b00, 32'h0));
        // I drops its request mid-grant; stray responses in RELEASE/IDLE ignored.
        vecs.push_back(mk(5'b10000, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b00000, 2'b10, 2'b01, 2'b00, 32'h200));
        vecs.push_back(mk(5'b00001, 2'b10, 2'b01, 2'b10, 32'h200));
        vecs.push_back(mk(5'b00001, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b00001, 2'b00, 2'b00, 2'b00, 32'h0));
        vecs.push_back(mk(5'b00000, 2'b00, 2'b00, 2'b00, 32'h0));

        // Reset: outputs quiet while rst is high and on the cycle after.
        repeat (2) @(negedge clk);
        bus.m_resp = 1'b1;
        #1;
        chk_out("in_rst", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("in_rst i_rdata", bus.i_rdata, '0);
        rst = 1'b0;
        @(negedge clk);
        bus.m_resp = 1'b0;
        #1;
        chk_out("post_rst", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("post_rst d_rdata", bus.d_rdata, '0);

        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            @(negedge clk);
            {bus.i_read, bus.i_write, bus.d_read, bus.d_write, bus.m_resp} = v.in;
            #1;
            exp_ird = (v.grant == 2'b01) ? RDATA : '0;
            exp_drd = (v.grant == 2'b10) ? RDATA : '0;
            exp_wd  = (v.grant == 2'b01) ? I_WDATA : (v.grant == 2'b10) ? D_WDATA : '0;
            chk($sformatf("v%0d m_rw", n), 128'({bus.m_read, bus.m_write}), 128'(v.mrw));
            chk($sformatf("v%0d grant", n), 128'(bus.grant), 128'(v.grant));
            chk($sformatf("v%0d resp", n), 128'({bus.i_resp, bus.d_resp}), 128'(v.resp));
            chk($sformatf("v%0d m_addr", n), 128'(bus.m_addr), 128'(v.addr));
            chk($sformatf("v%0d m_wdata", n), bus.m_wdata, exp_wd);
            chk($sformatf("v%0d i_rdata", n), bus.i_rdata, exp_ird);
            chk($sformatf("v%0d d_rdata", n), bus.d_rdata, exp_drd);
        end

        // Response on the last allowed cycle completes without error.
        @(negedge clk); bus.d_read = 1'b1; #1;
        chk_out("late idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); #1;
            chk_out($sformatf("late wait%0d", k), 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk); bus.m_resp = 1'b1; #1;
        chk_out("late done", 1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
        @(negedge clk); bus.m_resp = 1'b0; bus.d_read = 1'b0; #1;
        chk_out("late rel", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

        // Memory never answers: 8 cycles of m_read, then error response.
        @(negedge clk); bus.d_read = 1'b1; #1;
        chk_out("to idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            chk_out($sformatf("to wait%0d", k), 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk); #1;
        chk_out("to err", 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        chk("to err d_rdata", bus.d_rdata, '0);
        @(negedge clk); bus.d_read = 1'b0; #1;
        chk_out("to rel", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        @(negedge clk); bus.d_read = 1'b1; #1;
        chk_out("after idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        @(negedge clk); bus.m_resp = 1'b1; #1;
        chk_out("after done", 1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
        chk("after d_rdata", bus.d_rdata, RDATA);
        @(negedge clk); bus.m_resp = 1'b0; bus.d_read = 1'b0; #1;
        chk_out("after rel", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of an I wait, then a stray response.
        @(negedge clk); bus.i_read = 1'b1; #1;
        chk_out("rw idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk_out($sformatf("rw wait%0d", k), 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk); rst = 1'b1; bus.i_read = 1'b0; bus.m_resp = 1'b1; #1;
        chk_out("rw rst", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("rw rst i_rdata", bus.i_rdata, '0);
        @(negedge clk); rst = 1'b0; #1;
        chk_out("rw stray", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("rw stray i_rdata", bus.i_rdata, '0);
        @(negedge clk); bus.m_resp = 1'b0; #1;
        chk_out("rw idle2", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
